sfo_sweep_scheduler: RTL

Sequencer for `sfo_fft_correlator`. It sweeps a programmed range of SFO hypotheses for one CFO bin. For each hypothesis it loads the correlator, streams the stored FFT-magnitude buffer into it, and collects the correlation result. It keeps the best-scoring hypothesis and reports it at the end of the sweep, sitting between the FFT magnitude buffer and the downstream SFO/packet-timing logic.

---
 rtl/sfo_sweep_scheduler.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sfo_sweep_scheduler.sv
// sfo_sweep_scheduler
// Sweeps a range of SFO hypotheses for one CFO bin through sfo_fft_correlator.
// For each hypothesis it loads the correlator, streams the stored FFT-magnitude
// buffer into it, collects the score, and keeps the best-scoring hypothesis.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, abort_i        begin sweep (IDLE only) / cancel sweep
//   sfo_start_*_i           first hypothesis (int.frac)
//   sfo_step_*_i            per-hypothesis increment (int.frac)
//   num_hypotheses_i        hypotheses per sweep
//   fft_rd_en_o/addr_o      magnitude buffer read, data one cycle later
//   corr_sfo_*_o            hypothesis under test, held LOAD..COMPARE
//   corr_reset_o            correlator reset (low only in STREAM/DRAIN/WAIT)
//   corr_update_o           fft_rd_en_o delayed one cycle
//   corr_in_i/valid_i       correlator score, valid sticky until corr_reset
//   busy_o, done_o          sweep active / one-cycle end-of-sweep pulse
//   best_*_o                winning hypothesis, score, validity
//   timeout_count_o         hypotheses that produced no score (saturating)
//
// state   | meaning
// IDLE    | waiting for start, correlator held in reset
// LOAD    | correlator samples the new hypothesis
// STREAM  | read FFT bins 0..2^FFT_LEN_LOG2-1
// DRAIN   | last corr_update issues
// WAIT    | wait for score or timeout
// COMPARE | update best, advance hypothesis
// DONE    | one-cycle done pulse
module sfo_sweep_scheduler #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int SFO_INT_WIDTH  = 8,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 26,
  parameter int HYP_LOG2       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [SFO_INT_WIDTH-1:0]  sfo_start_int_i,
  input  logic [SFO_FRAC_WIDTH-1:0] sfo_start_frac_i,
  input  logic [SFO_INT_WIDTH-1:0]  sfo_step_int_i,
  input  logic [SFO_FRAC_WIDTH-1:0] sfo_step_frac_i,
  input  logic [HYP_LOG2-1:0]       num_hypotheses_i,
  output logic                      fft_rd_en_o,
  output logic [FFT_LEN_LOG2-1:0]   fft_rd_addr_o,
  output logic [SFO_INT_WIDTH-1:0]  corr_sfo_int_o,
  output logic [SFO_FRAC_WIDTH-1:0] corr_sfo_frac_o,
  output logic                      corr_reset_o,
  output logic                      corr_update_o,
  input  logic [CORR_WIDTH-1:0]     corr_in_i,
  input  logic                      corr_in_valid_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [SFO_INT_WIDTH-1:0]  best_sfo_int_o,
  output logic [SFO_FRAC_WIDTH-1:0] best_sfo_frac_o,
  output logic [CORR_WIDTH-1:0]     best_corr_o,
  output logic                      best_valid_o,
  output logic [HYP_LOG2-1:0]       timeout_count_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter preload: reaching zero on the last of TIMEOUT_CYCLES WAIT cycles.
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FFT_LEN_LOG2-1:0] ADDR_LAST = '1;

  logic [2:0]                state_q, state_d;
  logic [SFO_INT_WIDTH-1:0]  hyp_int_q, hyp_int_d;
  logic [SFO_FRAC_WIDTH-1:0] hyp_frac_q, hyp_frac_d;
  logic [SFO_INT_WIDTH-1:0]  step_int_q, step_int_d;
  logic [SFO_FRAC_WIDTH-1:0] step_frac_q, step_frac_d;
  logic [HYP_LOG2-1:0]       remaining_q, remaining_d;
  logic [FFT_LEN_LOG2-1:0]   addr_q, addr_d;
  logic [TW-1:0]             wait_cnt_q, wait_cnt_d;
  logic [CORR_WIDTH-1:0]     corr_lat_q, corr_lat_d;
  logic                      timed_out_q, timed_out_d;
  logic [SFO_INT_WIDTH-1:0]  best_int_q, best_int_d;
  logic [SFO_FRAC_WIDTH-1:0] best_frac_q, best_frac_d;
  logic [CORR_WIDTH-1:0]     best_corr_q, best_corr_d;
  logic                      best_valid_q, best_valid_d;
  logic [HYP_LOG2-1:0]       tcnt_q, tcnt_d;
  logic                      upd_q;

  logic                      frac_carry;
  logic [SFO_FRAC_WIDTH-1:0] frac_sum;
  logic [SFO_INT_WIDTH-1:0]  int_sum;

  // Hypothesis advance: carry out of the fractional add feeds the integer part.
  always_comb begin
    {frac_carry, frac_sum} = {1'b0, hyp_frac_q} + {1'b0, step_frac_q};
    int_sum = hyp_int_q + step_int_q + SFO_INT_WIDTH'(frac_carry);
  end

  always_comb begin
    state_d      = state_q;
    hyp_int_d    = hyp_int_q;
    hyp_frac_d   = hyp_frac_q;
    step_int_d   = step_int_q;
    step_frac_d  = step_frac_q;
    remaining_d  = remaining_q;
    addr_d       = addr_q;
    wait_cnt_d   = wait_cnt_q;
    corr_lat_d   = corr_lat_q;
    timed_out_d  = timed_out_q;
    best_int_d   = best_int_q;
    best_frac_d  = best_frac_q;
    best_corr_d  = best_corr_q;
    best_valid_d = best_valid_q;
    tcnt_d       = tcnt_q;

    if (abort_i && (state_q != S_IDLE)) begin
      // Partial best values are kept for debug, but flagged invalid.
      state_d      = S_IDLE;
      best_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            hyp_int_d    = sfo_start_int_i;
            hyp_frac_d   = sfo_start_frac_i;
            step_int_d   = sfo_step_int_i;
            step_frac_d  = sfo_step_frac_i;
            remaining_d  = num_hypotheses_i;
            best_int_d   = '0;
            best_frac_d  = '0;
            best_corr_d  = '0;
            best_valid_d = 1'b0;
            tcnt_d       = '0;
            state_d      = (num_hypotheses_i == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          addr_d  = '0;
          state_d = S_STREAM;
        end
        S_STREAM: begin
          addr_d = addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          // A score arriving on the final WAIT cycle still wins over timeout.
          if (corr_in_valid_i) begin
            corr_lat_d  = corr_in_i;
            timed_out_d = 1'b0;
            state_d     = S_COMPARE;
          end else if (wait_cnt_q == '0) begin
            timed_out_d = 1'b1;
            state_d     = S_COMPARE;
          end else begin
            wait_cnt_d = wait_cnt_q - 1'b1;
          end
        end
        S_COMPARE: begin
          if (!timed_out_q) begin
            // Strict compare: ties keep the earliest hypothesis.
            if (!best_valid_q || (corr_lat_q > best_corr_q)) begin
              best_int_d  = hyp_int_q;
              best_frac_d = hyp_frac_q;
              best_corr_d = corr_lat_q;
            end
            best_valid_d = 1'b1;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
          end
          hyp_int_d   = int_sum;
          hyp_frac_d  = frac_sum;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == HYP_LOG2'(1)) ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      hyp_int_q    <= '0;
      hyp_frac_q   <= '0;
      step_int_q   <= '0;
      step_frac_q  <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      wait_cnt_q   <= '0;
      corr_lat_q   <= '0;
      timed_out_q  <= 1'b0;
      best_int_q   <= '0;
      best_frac_q  <= '0;
      best_corr_q  <= '0;
      best_valid_q <= 1'b0;
      tcnt_q       <= '0;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hyp_int_q    <= hyp_int_d;
      hyp_frac_q   <= hyp_frac_d;
      step_int_q   <= step_int_d;
      step_frac_q  <= step_frac_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      wait_cnt_q   <= wait_cnt_d;
      corr_lat_q   <= corr_lat_d;
      timed_out_q  <= timed_out_d;
      best_int_q   <= best_int_d;
      best_frac_q  <= best_frac_d;
      best_corr_q  <= best_corr_d;
      best_valid_q <= best_valid_d;
      tcnt_q       <= tcnt_d;
      upd_q        <= (state_q == S_STREAM);
    end
  end

  assign fft_rd_en_o     = (state_q == S_STREAM);
  assign fft_rd_addr_o   = addr_q;
  assign corr_sfo_int_o  = hyp_int_q;
  assign corr_sfo_frac_o = hyp_frac_q;
  assign corr_reset_o    = !((state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_WAIT));
  assign corr_update_o   = upd_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign best_sfo_int_o  = best_int_q;
  assign best_sfo_frac_o = best_frac_q;
  assign best_corr_o     = best_corr_q;
  assign best_valid_o    = best_valid_q;
  assign timeout_count_o = tcnt_q;

endmodule
